// File: rtl/jtag_tdo_capture.sv
// rtl/jtag_tdo_capture.sv - packs strobed TDO bits LSB-first into vector RAM words
//
// Purpose: downstream of the JTAG vector player. Samples tdo on each tdo_valid
// strobe, packs bits LSB-first into J_D_WIDTH-bit words and writes them
// sequentially to the vector_2 RAM port. It is armed by start (jtag_rd), and
// busy/done/overflow status is reported back to the register block.
//
// Ports:
//   clk              system clock (same as vector_ram_clk)
//   reset            synchronous, active-high reset
//   start            one-cycle arm pulse; clears state, samples capture_len
//   capture_len      number of TDO bits to capture
//   tdo, tdo_valid   TDO bit and its one-cycle qualifier
//   vector_2_addr    RAM word address
//   vector_2_we      RAM write enable, one cycle per word
//   vector_2_wr_data packed TDO word
//   busy             high while capturing or flushing the final word
//   done             sticky completion flag
//   overflow         sticky; capture ran past RAM capacity
//   bits_captured    bits accepted since the last start
module jtag_tdo_capture #(
  parameter int J_D_WIDTH = 8,
  parameter int J_A_WIDTH = 12,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] capture_len,
  input  logic                 tdo,
  input  logic                 tdo_valid,
  output logic [J_A_WIDTH-1:0] vector_2_addr,
  output logic                 vector_2_we,
  output logic [J_D_WIDTH-1:0] vector_2_wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] bits_captured
);

  localparam int BW = (J_D_WIDTH > 1) ? $clog2(J_D_WIDTH) : 1;
  localparam logic [BW-1:0]        BIDX_LAST = BW'(J_D_WIDTH - 1);
  localparam logic [J_A_WIDTH-1:0] ADDR_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_FLUSH   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [J_D_WIDTH-1:0] r_sr;
  logic [BW-1:0]        r_bidx;
  logic [CNT_WIDTH-1:0] r_rem;
  logic [CNT_WIDTH-1:0] r_bits;
  logic [J_A_WIDTH-1:0] r_addr;
  logic [J_D_WIDTH-1:0] r_wdata;
  logic                 r_we;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_ovf;
  logic                 r_full;   // last RAM word has been written

  logic                 w_accept;
  logic                 w_ovf_hit;
  logic                 w_last;
  logic                 w_word_done;
  logic [J_D_WIDTH-1:0] w_word;

  // start always wins over a same-cycle tdo_valid, so the bit is dropped.
  always_comb begin
    w_accept    = (r_state == S_CAPTURE) && tdo_valid && !start && !r_full;
    w_ovf_hit   = (r_state == S_CAPTURE) && tdo_valid && !start && r_full;
    w_last      = w_accept && (r_rem == CNT_WIDTH'(1));
    w_word_done = w_accept && ((r_bidx == BIDX_LAST) || (r_rem == CNT_WIDTH'(1)));
    w_word      = r_sr | (J_D_WIDTH'(tdo) << r_bidx);
  end

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = (capture_len == '0) ? S_DONE : S_CAPTURE;
    end else begin
      case (r_state)
        S_CAPTURE: begin
          if (w_ovf_hit)   w_next = S_DONE;
          else if (w_last) w_next = S_FLUSH;
        end
        S_FLUSH: w_next = S_DONE;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr    <= '0;
      r_bidx  <= '0;
      r_rem   <= '0;
      r_bits  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      // Status flags mirror the state being entered so they line up with it.
      r_busy <= (w_next == S_CAPTURE) || (w_next == S_FLUSH);
      r_done <= (w_next == S_DONE);
      if (start) begin
        r_addr <= '0;
        r_bidx <= '0;
        r_sr   <= '0;
        r_bits <= '0;
        r_ovf  <= 1'b0;
        r_full <= 1'b0;
        r_rem  <= capture_len;
      end else begin
        // Address advances after each write but parks on the last word.
        if (r_we && (r_addr != ADDR_MAX)) r_addr <= r_addr + J_A_WIDTH'(1);
        if (w_ovf_hit) r_ovf <= 1'b1;
        if (w_accept) begin
          r_bits <= r_bits + CNT_WIDTH'(1);
          r_rem  <= r_rem - CNT_WIDTH'(1);
          if (w_word_done) begin
            r_we    <= 1'b1;
            r_wdata <= w_word;
            r_sr    <= '0;
            r_bidx  <= '0;
            if (r_addr == ADDR_MAX) r_full <= 1'b1;
          end else begin
            r_sr   <= w_word;
            r_bidx <= r_bidx + BW'(1);
          end
        end
      end
    end
  end

  assign vector_2_addr    = r_addr;
  assign vector_2_we      = r_we;
  assign vector_2_wr_data = r_wdata;
  assign busy             = r_busy;
  assign done             = r_done;
  assign overflow         = r_ovf;
  assign bits_captured    = r_bits;

endmodule

// File: tb/tb_jtag_tdo_capture.sv
// tb/tb_jtag_tdo_capture.sv - scoreboard bench for jtag_tdo_capture
module tb_jtag_tdo_capture;

  localparam int CAP = 8 * 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] capture_len;
  logic        tdo;
  logic        tdo_valid;
  logic [11:0] vector_2_addr;
  logic        vector_2_we;
  logic [7:0]  vector_2_wr_data;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] bits_captured;

  jtag_tdo_capture dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .capture_len      (capture_len),
    .tdo              (tdo),
    .tdo_valid        (tdo_valid),
    .vector_2_addr    (vector_2_addr),
    .vector_2_we      (vector_2_we),
    .vector_2_wr_data (vector_2_wr_data),
    .busy             (busy),
    .done             (done),
    .overflow         (overflow),
    .bits_captured    (bits_captured)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t exp_q[$];
  bit  stim[0:CAP+15];
  int  cyc = 0;
  int  n_total = 0;
  int  n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every write the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (vector_2_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", vector_2_addr, vector_2_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", int'(vector_2_addr), e.addr);
        chk("wr_data", int'(vector_2_wr_data), e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word k holds bits 8k..8k+7, LSB first; a short final word is zero padded.
  task automatic push_word(input int i);
    wr_t e;
    int  k;
    int  w;
    k = i / 8;
    w = 0;
    for (int j = 8 * k; j <= i; j++) w = w | (int'(stim[j]) << (j - 8 * k));
    e.addr = k;
    e.data = w;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input int len);
    tick();
    start = 1'b1;
    capture_len = 16'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic drive_bits(input int len, input int nsend, input int gap);
    for (int i = 0; i < nsend; i++) begin
      tick();
      tdo_valid = 1'b1;
      tdo = stim[i];
      if (i < len && i < CAP && ((i % 8) == 7 || i == len - 1)) push_word(i);
      if (gap > 0) begin
        tick();
        tdo_valid = 1'b0;
        repeat (gap - 1) tick();
      end
    end
    tick();
    tdo_valid = 1'b0;
  endtask

  task automatic chk_status(input string tag, input int bits, input int d, input int ovf);
    repeat (3) tick();
    @(negedge clk);
    chk({tag, "_bits"}, int'(bits_captured), bits);
    chk({tag, "_done"}, int'(done), d);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ovf"}, int'(overflow), ovf);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, int'(vector_2_addr), 0);
    chk({tag, "_we"}, int'(vector_2_we), 0);
    chk({tag, "_data"}, int'(vector_2_wr_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
    chk({tag, "_bits"}, int'(bits_captured), 0);
  endtask

  initial begin
    bit t1 [16];
    int len;
    int gap;
    t1 = '{1,0,1,1,0,0,0,0, 1,1,1,1,0,0,0,0};
    reset = 1'b1;
    start = 1'b0;
    capture_len = '0;
    tdo = 1'b0;
    tdo_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk_reset_vals("reset");
    tick();
    reset = 1'b0;

    // 1: two full words back to back, busy drops after the flush cycle
    for (int i = 0; i < 16; i++) stim[i] = t1[i];
    do_start(16);
    drive_bits(16, 16, 0);
    @(negedge clk);
    chk("t1_busy_flush", int'(busy), 1);
    @(negedge clk);
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_done_after", int'(done), 1);
    chk_status("t1", 16, 1, 0);

    // 2: partial final word, spaced strobes
    for (int i = 0; i < 11; i++) stim[i] = 1'b1;
    do_start(11);
    drive_bits(11, 11, 4);
    chk_status("t2", 11, 1, 0);

    // 3: zero-length capture
    tick();
    start = 1'b1;
    capture_len = 16'd0;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("t3_done", int'(done), 1);
    chk("t3_busy", int'(busy), 0);
    chk_status("t3", 0, 1, 0);

    // 4: overrun past RAM capacity, two extra strobes
    for (int i = 0; i < CAP + 2; i++) stim[i] = 1'($urandom_range(0, 1));
    do_start(CAP + 2);
    drive_bits(CAP + 2, CAP + 2, 0);
    chk_status("t4", CAP, 1, 1);
    chk("t4_addr_nowrap", int'(vector_2_addr), 12'hFFF);

    // 5: abort after 9 bits, then a fresh 8-bit run
    for (int i = 0; i < 9; i++) stim[i] = 1'($urandom_range(0, 1));
    do_start(20);
    drive_bits(20, 9, 0);
    repeat (2) tick();
    do_start(8);
    @(negedge clk);
    chk("t5_done_cleared", int'(done), 0);
    chk("t5_busy_rearm", int'(busy), 1);
    chk("t5_bits_cleared", int'(bits_captured), 0);
    for (int i = 0; i < 8; i++) stim[i] = 1'($urandom_range(0, 1));
    drive_bits(8, 8, 0);
    chk_status("t5", 8, 1, 0);

    // random runs
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 40);
      gap = $urandom_range(0, 3);
      for (int i = 0; i < len; i++) stim[i] = 1'($urandom_range(0, 1));
      do_start(len);
      drive_bits(len, len, gap);
      chk_status("rand", len, 1, 0);
    end

    // 6: reset lands on the word-completing strobe
    for (int i = 0; i < 8; i++) stim[i] = 1'($urandom_range(0, 1));
    do_start(8);
    drive_bits(8, 7, 0);
    tdo_valid = 1'b1;
    tdo = stim[7];
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tdo_valid = 1'b0;
    @(negedge clk);
    chk_reset_vals("t6");
    for (int i = 0; i < 10; i++) stim[i] = 1'b1;
    drive_bits(0, 10, 0);
    chk_status("t6_idle", 0, 0, 0);

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jtag_tdo_capture.md
Name: jtag_tdo_capture

Overview:
Downstream stage of the JTAG vector player and signal output stage. It samples the resynchronised TDO bit on each per-TCK valid strobe and packs the bits LSB-first into J_D_WIDTH-bit words. It writes those words sequentially into the second vector RAM port (vector_2) of main_ram, so the CPU can read the captured response after a run. It is armed by the control-register read strobe (jtag_rd) and reports busy/done/overflow status back to the register block.

Parameters:
J_D_WIDTH, 8, bits per vector RAM word
J_A_WIDTH, 12, vector RAM address width (capacity = J_D_WIDTH*2^J_A_WIDTH = 32768 bits)
CNT_WIDTH, 16, width of capture length and bit counters

Ports:
clk  in  1  system clock (same clk as vector_ram_clk)
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse (jtag_rd): clear state and arm capture
capture_len  in  CNT_WIDTH  number of TDO bits to capture; sampled on start
tdo  in  1  TDO bit from the signal output stage
tdo_valid  in  1  one-cycle strobe: tdo holds a new bit this cycle
vector_2_addr  out  J_A_WIDTH  RAM word address
vector_2_we  out  1  RAM write enable, one cycle per word
vector_2_wr_data  out  J_D_WIDTH  packed TDO word
busy  out  1  high in CAPTURE and FLUSH
done  out  1  sticky; set on completion, cleared by start or reset
overflow  out  1  sticky; capture exceeded RAM capacity
bits_captured  out  CNT_WIDTH  bits accepted since last start

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values: vector_2_addr=0, vector_2_we=0, vector_2_wr_data=0, busy=0, done=0, overflow=0, bits_captured=0, state=IDLE.
- Internal state: shift register sr[J_D_WIDTH-1:0], bit index bidx (log2 J_D_WIDTH bits), remaining count rem, latched length.
- States are IDLE, CAPTURE, FLUSH, DONE.
- IDLE:
  - tdo_valid is ignored.
  - On start: clear addr, bidx, sr, bits_captured, done and overflow; load rem=capture_len.
  - If capture_len==0, go to DONE (done=1 next cycle, no writes). Otherwise go to CAPTURE.
- CAPTURE, on tdo_valid:
  - sr[bidx]<=tdo, bidx++, bits_captured++, rem--.
  - If bidx==J_D_WIDTH-1, or rem==1 (last bit): on the next cycle present vector_2_wr_data = completed word, with unused upper bits zero on a partial last word. Assert vector_2_we for exactly one cycle at the current addr. Clear sr and bidx.
  - addr increments in the cycle after the write.
  - When the last bit is accepted, go to FLUSH.
- FLUSH: lasts one cycle while the final write issues, then go to DONE.
- DONE: done=1, busy=0. Remain until start, which re-arms exactly as from IDLE.
- Write latency: vector_2_we is high in the cycle after the tdo_valid that completes a word. A full word never stalls; tdo_valid may assert on consecutive cycles.
- Overflow:
  - If a word completes while addr==2^J_A_WIDTH-1, it is written and addr does not wrap; an internal full flag is set.
  - Any further tdo_valid in CAPTURE sets overflow=1 and moves to DONE. No further writes occur and that bit is not counted.
- Simultaneous events:
  - start in CAPTURE or FLUSH aborts the run. Any pending write in that same cycle is suppressed, and the block restarts from the start-load step; done is not set for the aborted run.
  - start and tdo_valid in the same cycle: start wins and the bit is discarded.
  - reset has priority over everything, including mid-write.
- busy=1 exactly in CAPTURE and FLUSH.

Test Plan:
1. Reset, then start with capture_len=16 and TDO bits 1,0,1,1,0,0,0,0, 1,1,1,1,0,0,0,0 on back-to-back tdo_valid. Expect writes addr0=0x0D and addr1=0x0F, each with we high one cycle; done=1; bits_captured=16; busy drops the cycle after FLUSH.
2. capture_len=11, all bits 1, tdo_valid every 5 cycles. Expect addr0=0xFF and addr1=0x07 (zero-padded), exactly 2 writes, done=1.
3. capture_len=0. Expect no we, done=1 one cycle after start, busy never asserted.
4. capture_len=32770 with continuous tdo_valid. Expect 4096 writes (last at addr 0xFFF), overflow=1, done=1, bits_captured=32768, no address wrap.
5. capture_len=20; after 9 bits, pulse start with capture_len=8. Expect the write of word 0 only from the first run; the second run rewrites addr0 with its 8 bits; done only after the second run; bits_captured=8.
6. Assert reset during the cycle vector_2_we would rise. Expect no write, all outputs at reset values the next cycle; tdo_valid afterwards is ignored until start.
